// File: rtl/mux_dec_arbiter.sv
// Round-robin arbiter and break-before-make sequencer for the shared mux_2x1 -> dec_3x8 path.
// The decoder is held disabled for one cycle on either side of every select change.
module mux_dec_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic sel_o,
  output logic en_o,
  output logic done0_o,
  output logic done1_o,
  output logic busy_o
);

  // state   | meaning
  // IDLE    | no owner, decoder off, arbitrating every cycle
  // SETUP   | select switched to the winner, decoder still off
  // ACTIVE  | decoder on for the owner, counting the hold window
  // RELEASE | decoder off, grant dropped, arbitrating for the next owner
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_RELEASE} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, sel_q, sel_d, en_q, en_d;
  logic             done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;

  logic any_req, winner, owner_req, hold_done;

  assign any_req   = req0_i | req1_i;
  // on a tie the requester that did not hold the last grant wins
  assign winner    = (req0_i & req1_i) ? ~last_q : req1_i;
  assign owner_req = last_q ? req1_i : req0_i;
  assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (any_req) begin
          state_d = S_SETUP;
          last_d  = winner;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = owner_req ? S_ACTIVE : S_RELEASE;
      S_ACTIVE: if (!owner_req || hold_done) state_d = S_RELEASE;
      default:  state_d = S_IDLE;
    endcase
  end

  // outputs are registered copies of what the next state implies
  always_comb begin
    sel_d   = (state_d == S_SETUP) ? last_d : sel_q;
    en_d    = (state_d == S_ACTIVE);
    gnt0_d  = ((state_d == S_SETUP) || (state_d == S_ACTIVE)) && !last_d;
    gnt1_d  = ((state_d == S_SETUP) || (state_d == S_ACTIVE)) &&  last_d;
    busy_d  = (state_d != S_IDLE);
    done0_d = (state_q == S_ACTIVE) && owner_req && hold_done && !last_q;
    done1_d = (state_q == S_ACTIVE) && owner_req && hold_done &&  last_q;
    cnt_d   = '0;
    if (state_d == S_ACTIVE)
      cnt_d = (state_q == S_SETUP) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  end

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign sel_o   = sel_q;
  assign en_o    = en_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_mux_dec_arbiter.sv
// Scoreboarded bench for mux_dec_arbiter: grant records queued by stimulus, checked by a monitor.
module tb_mux_dec_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic gnt0, gnt1, sel, en, done0, done1, busy;
  logic req0b = 1'b0, req1b = 1'b0;
  logic gnt0b, gnt1b, selb, enb, done0b, done1b, busyb;

  always #5 clk = ~clk;

  mux_dec_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0_i(req0), .req1_i(req1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .sel_o(sel), .en_o(en),
    .done0_o(done0), .done1_o(done1), .busy_o(busy)
  );

  mux_dec_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0_i(req0b), .req1_i(req1b),
    .gnt0_o(gnt0b), .gnt1_o(gnt1b), .sel_o(selb), .en_o(enb),
    .done0_o(done0b), .done1_o(done1b), .busy_o(busyb)
  );

  typedef struct {
    bit who;
    int en_len;
    bit done;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   sb_on = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit who, input int en_len, input bit done);
    rec_t r;
    r.who = who; r.en_len = en_len; r.done = done;
    exp_q.push_back(r);
  endtask

  // which: 0 = done0, 1 = done1, 2 = busy low
  task automatic wait_for(input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = (which == 0) ? done0 : (which == 1) ? done1 : !busy;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout_%s actual=0 required=1", name);
    end
  endtask

  // monitor: invariants every cycle, grant record compared on each RELEASE cycle
  bit in_grant = 1'b0;
  bit m_who    = 1'b0;
  int m_en     = 0;
  bit prev_sel = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_grant = 1'b0;
    end else begin
      chk("inv_gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("inv_en_gnt", {31'd0, en & !(gnt0 | gnt1)}, 32'd0);
      chk("inv_sel_en", {31'd0, en & (sel != prev_sel)}, 32'd0);
      if (gnt0 | gnt1) begin
        if (!in_grant) begin
          in_grant = 1'b1;
          m_who    = gnt1;
          m_en     = 0;
        end
        if (en) m_en++;
      end else if (in_grant) begin
        in_grant = 1'b0;
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_grant", 32'd1, 32'd0);
          end else begin
            rec_t r;
            r = exp_q.pop_front();
            chk("sb_who", {31'd0, m_who}, {31'd0, r.who});
            chk("sb_en_len", m_en, r.en_len);
            chk("sb_done", {31'd0, m_who ? done1 : done0}, {31'd0, r.done});
            chk("sb_other_done", {31'd0, m_who ? done0 : done1}, 32'd0);
          end
        end
      end
    end
    prev_sel = sel;
  end

  initial begin
    // 1: both requesting through reset release; alternation and exact timing
    req0 = 1'b1; req1 = 1'b1;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    rst_n = 1'b1;
    push(1'b0, 4, 1'b1);
    push(1'b1, 4, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("t1_en_c%0d", c), {31'd0, en}, {31'd0, (c >= 2 && c <= 5) || (c >= 8 && c <= 11)});
      chk($sformatf("t1_gnt0_c%0d", c), {31'd0, gnt0}, {31'd0, c <= 5});
      chk($sformatf("t1_gnt1_c%0d", c), {31'd0, gnt1}, {31'd0, c >= 7 && c <= 11});
      chk($sformatf("t1_sel_c%0d", c), {31'd0, sel}, {31'd0, c >= 7});
      chk($sformatf("t1_done0_c%0d", c), {31'd0, done0}, {31'd0, c == 6});
      chk($sformatf("t1_done1_c%0d", c), {31'd0, done1}, {31'd0, c == 12});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: requester 1 alone
    req1 = 1'b1;
    push(1'b1, 4, 1'b1);
    tick();
    chk("t2_setup_sel", {31'd0, sel}, 32'd1);
    chk("t2_setup_en", {31'd0, en}, 32'd0);
    wait_for(1, "t2_done1");
    req1 = 1'b0;
    tick();
    chk("t2_done1_single", {31'd0, done1}, 32'd0);
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    chk("t2_idle_sel", {31'd0, sel}, 32'd1);

    // 3: requester 0 aborts after two ACTIVE cycles, pending requester 1 follows
    req0 = 1'b1;
    push(1'b0, 2, 1'b0);
    tick();
    chk("t3_setup_sel", {31'd0, sel}, 32'd0);
    req1 = 1'b1;
    tick(); tick();
    chk("t3_active_en", {31'd0, en}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("t3_rel_en", {31'd0, en}, 32'd0);
    chk("t3_rel_gnt0", {31'd0, gnt0}, 32'd0);
    chk("t3_rel_done0", {31'd0, done0}, 32'd0);
    chk("t3_rel_busy", {31'd0, busy}, 32'd1);
    push(1'b1, 4, 1'b1);
    tick();
    chk("t3_next_gnt1", {31'd0, gnt1}, 32'd1);
    chk("t3_next_sel", {31'd0, sel}, 32'd1);
    wait_for(1, "t3_done1");
    req1 = 1'b0;
    wait_for(2, "t3_idle");

    // 4: random request stream, invariants only
    sb_on = 1'b0;
    for (int i = 0; i < 200; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_for(2, "t4_idle");
    tick();
    sb_on = 1'b1;

    // 5: reset during ACTIVE, then first tie goes to requester 0
    req1 = 1'b1;
    tick(); tick(); tick();
    chk("t5_active_en", {31'd0, en}, 32'd1);
    chk("t5_active_sel", {31'd0, sel}, 32'd1);
    req0 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_en", {31'd0, en}, 32'd0);
    chk("t5_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("t5_rst_sel", {31'd0, sel}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_done", {30'd0, done1, done0}, 32'd0);
    tick();
    rst_n = 1'b1;
    push(1'b0, 4, 1'b1);
    tick();
    chk("t5_tie_gnt0", {31'd0, gnt0}, 32'd1);
    chk("t5_tie_sel", {31'd0, sel}, 32'd0);
    req1 = 1'b0;
    wait_for(0, "t5_done0");
    req0 = 1'b0;
    wait_for(2, "t5_idle");

    // 6: HOLD_CYCLES = 1 instance, both held: 3-cycle grants alternating 0,1
    req0b = 1'b1; req1b = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      int ph, g;
      tick();
      ph = (c - 1) % 3;
      g  = (c - 1) / 3;
      chk($sformatf("t6_en_c%0d", c), {31'd0, enb}, {31'd0, ph == 1});
      chk($sformatf("t6_sel_c%0d", c), {31'd0, selb}, g % 2);
      chk($sformatf("t6_done0_c%0d", c), {31'd0, done0b}, {31'd0, ph == 2 && g % 2 == 0});
      chk($sformatf("t6_done1_c%0d", c), {31'd0, done1b}, {31'd0, ph == 2 && g % 2 == 1});
    end
    req0b = 1'b0; req1b = 1'b0;

    tick(); tick();
    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_dec_arbiter.md
Name: mux_dec_arbiter

Overview:
- Synchronous round-robin arbiter and sequencer for the shared mux_2x1 → dec_3x8 address path.
- Two requesters each present a 3-bit address on the mux data inputs (in1 = requester 0, in2 = requester 1); this block drives the mux select and the decoder enable.
- Switching is break-before-make: the decoder is disabled before select changes, so the decoder output never glitches between requesters.
- Grants hold the decoder enabled for a fixed window.

Parameters:
- HOLD_CYCLES, 4, number of consecutive cycles en is high per grant; legal range 1..255.
- CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 wants the decoder; level, held until done0 or withdrawn.
- req1  input  1  requester 1 wants the decoder.
- gnt0  output  1  requester 0 owns the path (SETUP and ACTIVE).
- gnt1  output  1  requester 1 owns the path.
- sel  output  1  mux select to mux_2x1: 0 = in1/requester 0, 1 = in2/requester 1.
- en  output  1  enable to dec_3x8.
- done0  output  1  one-cycle pulse: requester 0 window completed.
- done1  output  1  one-cycle pulse: requester 1 window completed.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset is asynchronous on rst_n low and releases synchronously on the clock.
- Reset values:
  - state = IDLE; sel = 0; en = 0; gnt0 = gnt1 = 0; done0 = done1 = 0; busy = 0; cnt = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- States: IDLE, SETUP, ACTIVE, RELEASE.
- IDLE:
  - If any req is high, go to SETUP next cycle.
  - Winner = the only requester, or on a tie the requester other than last_grant.
  - In SETUP: sel = winner, gnt(winner) = 1, en = 0, last_grant = winner.
  - Otherwise stay in IDLE; sel holds its last value.
- SETUP (exactly 1 cycle):
  - If req(winner) is still high, go to ACTIVE: en = 1, cnt = 1.
  - If req(winner) has dropped, go to RELEASE (abort).
- ACTIVE:
  - en = 1 and sel is stable.
  - If req(winner) drops, go to RELEASE next cycle with no done pulse (abort).
  - Else if cnt == HOLD_CYCLES, go to RELEASE and pulse done(winner) in that RELEASE cycle.
  - Else cnt = cnt + 1.
  - en is high for exactly HOLD_CYCLES cycles on a full completion.
- RELEASE (exactly 1 cycle):
  - en = 0, gnt0 = gnt1 = 0; sel is unchanged.
  - Next cycle arbitrates exactly as IDLE does. A pending request goes straight to SETUP; otherwise go to IDLE.
- Timing:
  - Minimum request-to-en latency is 2 cycles (req sampled in IDLE → SETUP → ACTIVE).
  - Per-grant occupancy is HOLD_CYCLES + 2 cycles.
- Invariants:
  - sel only changes on entry to SETUP, and en is 0 in that cycle.
  - gnt0 and gnt1 are never both high.
  - en == 1 implies exactly one gnt is high.
  - done pulses are mutually exclusive and occur only in RELEASE.
- Fairness: with both req held continuously, grants alternate 0,1,0,1…
- A requester re-asserting req in the same cycle as its done pulse is treated as a new request and loses any tie.
- Reset mid-grant: en and gnt drop immediately (asynchronously), sel returns to 0, and no done pulse is generated.

Test Plan:
- Reset with req0 = req1 = 1 held, then release: gnt0 rises at cycle 1 with sel = 0 and en = 0; en = 1 for cycles 2–5; cycle 6 is RELEASE with done0 = 1 and en = 0; cycle 7 is SETUP with sel = 1 and gnt1 = 1; en = 1 for cycles 8–11.
- req1 only: sel = 1 in SETUP, en is high for 4 cycles, done1 is a single-cycle pulse, then IDLE with busy = 0 and sel still 1.
- req0 dropped after 2 ACTIVE cycles: next cycle is RELEASE with en = 0, gnt0 = 0 and no done0; a pending req1 is granted in the following cycle.
- Break-before-make check: over a 200-cycle random req stream, assert that en is never 1 in a cycle where sel differed from the previous cycle, that gnt0 & gnt1 never occurs, and that en implies a gnt.
- Assert rst_n low during ACTIVE with en = 1: en, gnt, sel and busy are all 0 before the next clock edge; after release, the first tie goes to requester 0.
- With HOLD_CYCLES = 1, both requesters held: the en pattern repeats 0,1,0 per grant, with sel alternating 0,1 each 3-cycle grant.
